// File: rtl/if_id_stage_pkg.sv
// Shared CPU definitions: word width, reset/NOP constants, and the IF/ID FSM encoding.
`timescale 1ns/1ps
package if_id_stage_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEF  = 16'h0000;
  localparam word_t NOP_INSTR_DEF = 16'h0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Sequential PC increment; wraps naturally at 2^WORD_W.
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(2);
  endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: next-PC selection, one-deep in-flight fetch tracking,
// and the decode register with stall buffering and branch squash.
//
// state  | meaning
// S_BOOT | first cycle after reset; PC held so address RESET_PC is not skipped
// S_RUN  | normal fetch; decode loads from the in-flight slot and memory data
// S_HOLD | stalled; memory data for the in-flight slot parked in hold_instr
`timescale 1ns/1ps
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazrd,
  input  logic        flush,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] pc_in,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic        imem_en,
  output logic [15:0] pc_next,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_plus2,
  output logic [15:0] id_instr,
  output logic        id_valid
);

  state_t state_q, state_d;

  word_t f_pc;
  logic  f_valid;
  word_t hold_instr;

  logic id_ld_run;
  logic id_ld_hold;
  logic hold_ld;
  logic f_ld;
  logic squash;

  assign imem_addr = pc_in;
  assign imem_en   = ~(hazrd & ~flush);

  // Next-PC mux: redirect beats stall; stall and boot both hold the PC.
  always_comb begin
    pc_next = pc_inc(pc_in);
    if (flush) begin
      pc_next = redirect_pc;
    end else if (hazrd || (state_q == S_BOOT)) begin
      pc_next = pc_in;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and datapath load enables; flush overrides everything.
  always_comb begin
    state_d    = state_q;
    id_ld_run  = 1'b0;
    id_ld_hold = 1'b0;
    hold_ld    = 1'b0;
    f_ld       = 1'b0;
    squash     = 1'b0;
    if (flush) begin
      squash  = 1'b1;
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (hazrd) begin
            hold_ld = 1'b1;
            state_d = S_HOLD;
          end else begin
            id_ld_run = 1'b1;
            f_ld      = 1'b1;
          end
        end
        S_HOLD: begin
          if (!hazrd) begin
            id_ld_hold = 1'b1;
            f_ld       = 1'b1;
            state_d    = S_RUN;
          end
        end
        default: state_d = S_BOOT;
      endcase
    end
  end

  // In-flight slot, stall buffer and decode registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_pc        <= RESET_PC;
      f_valid     <= 1'b0;
      hold_instr  <= NOP_INSTR;
      id_pc       <= RESET_PC;
      id_pc_plus2 <= pc_inc(RESET_PC);
      id_instr    <= NOP_INSTR;
      id_valid    <= 1'b0;
    end else if (squash) begin
      f_pc     <= pc_in;
      f_valid  <= 1'b0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      if (id_ld_run) begin
        id_pc       <= f_pc;
        id_pc_plus2 <= pc_inc(f_pc);
        id_instr    <= f_valid ? imem_data : NOP_INSTR;
        id_valid    <= f_valid;
      end
      if (id_ld_hold) begin
        id_pc       <= f_pc;
        id_pc_plus2 <= pc_inc(f_pc);
        id_instr    <= f_valid ? hold_instr : NOP_INSTR;
        id_valid    <= f_valid;
      end
      if (hold_ld) begin
        hold_instr <= imem_data;
      end
      if (f_ld) begin
        f_pc    <= pc_in;
        f_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed corner sequences, a
// combinational next-PC vector table, and randomized traffic against a
// queue-based model of which fetched addresses reach decode.
`timescale 1ns/100ps
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazrd = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] pc_in;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic        imem_en;
  logic [15:0] pc_next;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus2;
  logic [15:0] id_instr;
  logic        id_valid;

  logic [15:0] pc_q;
  logic        force_en = 1'b0;
  logic [15:0] force_pc = 16'h0000;

  int checks = 0;
  int failures = 0;

  // model: fetched-but-not-decoded addresses, expected decode slot
  logic [15:0] q[$];
  logic        m_boot;
  logic [15:0] m_pc;
  logic        m_valid;

  typedef struct {
    logic [15:0] pc;
    logic        h;
    logic        f;
    logic [15:0] r;
    logic [15:0] exp_next;
    logic        exp_en;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  assign pc_in = force_en ? force_pc : pc_q;

  if_id_stage dut (
    .clk(clk),
    .rst(rst),
    .hazrd(hazrd),
    .flush(flush),
    .redirect_pc(redirect_pc),
    .pc_in(pc_in),
    .imem_data(imem_data),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .pc_next(pc_next),
    .id_pc(id_pc),
    .id_pc_plus2(id_pc_plus2),
    .id_instr(id_instr),
    .id_valid(id_valid)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1111;
    if (a == 16'h0002) return 16'h2222;
    return a ^ 16'hA5C3;
  endfunction

  // PC register
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= 16'h0000;
    else pc_q <= pc_next;
  end

  // synchronous instruction memory
  always @(posedge clk) begin
    if (imem_en) imem_data <= memf(imem_addr);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_boot  = 1'b1;
    m_pc    = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic h, input logic f, input logic [15:0] pc);
    if (f) begin
      q.delete();
      m_valid = 1'b0;
      m_boot  = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!h) begin
      if (q.size() > 0) begin
        m_pc    = q.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      q.push_back(pc);
    end
  endtask

  // one clock: drive, check combinational outputs, advance model, check decode
  task automatic cyc(input logic h, input logic f, input logic [15:0] r);
    logic [15:0] exp_next;
    hazrd = h;
    flush = f;
    redirect_pc = r;
    #1;
    if (f) exp_next = r;
    else if (h || m_boot) exp_next = pc_in;
    else exp_next = pc_in + 16'd2;
    chk("pc_next", pc_next, exp_next);
    chk("imem_en", {15'd0, imem_en}, {15'd0, ~(h & ~f)});
    model_step(h, f, pc_in);
    @(posedge clk);
    #1;
    chk("id_valid", {15'd0, id_valid}, {15'd0, m_valid});
    if (m_valid) begin
      chk("id_pc", id_pc, m_pc);
      chk("id_pc_plus2", id_pc_plus2, m_pc + 16'd2);
      chk("id_instr", id_instr, memf(m_pc));
    end else begin
      chk("id_instr_nop", id_instr, 16'h0000);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_id_pc", id_pc, 16'h0000);
    chk("rst_id_pc_plus2", id_pc_plus2, 16'h0002);
    chk("rst_id_instr", id_instr, 16'h0000);
    chk("rst_id_valid", {15'd0, id_valid}, 16'h0000);
  endtask

  // start-up fetch of 0000 and 0002
  task automatic boot_seq();
    cyc(0, 0, 16'h0);
    chk("boot_e1_valid", {15'd0, id_valid}, 16'h0000);
    cyc(0, 0, 16'h0);
    chk("boot_e2_valid", {15'd0, id_valid}, 16'h0000);
    cyc(0, 0, 16'h0);
    chk("boot_e3_valid", {15'd0, id_valid}, 16'h0001);
    chk("boot_e3_pc", id_pc, 16'h0000);
    chk("boot_e3_instr", id_instr, 16'h1111);
    cyc(0, 0, 16'h0);
    chk("boot_e4_pc", id_pc, 16'h0002);
    chk("boot_e4_instr", id_instr, 16'h2222);
  endtask

  initial begin
    vecs[0] = '{16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0012, 1'b1};
    vecs[1] = '{16'h0010, 1'b1, 1'b0, 16'h0000, 16'h0010, 1'b0};
    vecs[2] = '{16'h0010, 1'b0, 1'b1, 16'h0124, 16'h0124, 1'b1};
    vecs[3] = '{16'h0010, 1'b1, 1'b1, 16'h0200, 16'h0200, 1'b1};
    vecs[4] = '{16'hFFFE, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1};
    vecs[5] = '{16'hFFFE, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 1'b0};
    vecs[6] = '{16'h7FFE, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1};
    vecs[7] = '{16'hFFFE, 1'b1, 1'b1, 16'h1000, 16'h1000, 1'b1};

    model_reset();
    #12;
    chk_reset_values();
    @(negedge clk);
    rst = 1'b1;

    boot_seq();

    // stall with 0004 in flight
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0);
      chk("stall_hold_pc", id_pc, 16'h0002);
      chk("stall_imem_en", {15'd0, imem_en}, 16'h0000);
    end
    cyc(0, 0, 16'h0);
    chk("stall_rel_pc", id_pc, 16'h0004);
    chk("stall_rel_instr", id_instr, memf(16'h0004));
    cyc(0, 0, 16'h0);
    chk("stall_next_pc", id_pc, 16'h0006);

    // flush during steady fetch
    cyc(0, 1, 16'h0040);
    chk("flush_valid", {15'd0, id_valid}, 16'h0000);
    chk("flush_instr", id_instr, 16'h0000);
    cyc(0, 0, 16'h0);
    chk("flush_e1_valid", {15'd0, id_valid}, 16'h0000);
    cyc(0, 0, 16'h0);
    chk("flush_e2_pc", id_pc, 16'h0040);
    chk("flush_e2_valid", {15'd0, id_valid}, 16'h0001);

    // flush together with hazard while holding
    cyc(1, 0, 16'h0);
    cyc(1, 0, 16'h0);
    cyc(1, 1, 16'h0080);
    chk("hold_flush_valid", {15'd0, id_valid}, 16'h0000);
    cyc(0, 0, 16'h0);
    cyc(0, 0, 16'h0);
    chk("hold_flush_pc", id_pc, 16'h0080);

    // combinational next-PC table, applied between clock edges
    @(negedge clk);
    force_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      force_pc = vecs[i].pc;
      hazrd = vecs[i].h;
      flush = vecs[i].f;
      redirect_pc = vecs[i].r;
      #0.4;
      chk("tbl_pc_next", pc_next, vecs[i].exp_next);
      chk("tbl_imem_en", {15'd0, imem_en}, {15'd0, vecs[i].exp_en});
      chk("tbl_imem_addr", imem_addr, vecs[i].pc);
    end
    force_en = 1'b0;
    hazrd = 1'b0;
    flush = 1'b0;

    // wrap at FFFE
    cyc(0, 1, 16'hFFFE);
    cyc(0, 0, 16'h0);
    cyc(0, 0, 16'h0);
    chk("wrap_pc", id_pc, 16'hFFFE);
    chk("wrap_pc_plus2", id_pc_plus2, 16'h0000);
    cyc(0, 0, 16'h0);
    chk("wrap_next_pc", id_pc, 16'h0000);

    // reset pulse mid-stall
    cyc(1, 0, 16'h0);
    cyc(1, 0, 16'h0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_values();
    model_reset();
    hazrd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    boot_seq();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 10) == 0, {$urandom_range(0, 32767), 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
